// File: rtl/uart_rx_param.sv
// Parametrised asynchronous serial receiver: configurable data width, parity and
// stop bits, with start-bit validation, error flags and a valid/ready output.
module uart_rx_param #(
    parameter int unsigned BAUD_DIV  = 104,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned HALF  = BAUD_DIV / 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP1 = 3'd4,
        STOP2 = 3'd5
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit_q;
    logic                 par_err_q;
    logic                 stop1_q;

    logic                 bit_tick;
    logic                 finish;
    logic                 stop1_val;
    logic                 fe_val;
    logic                 bd_val;

    // Frame completion happens on the last stop sample; flags are built from the
    // samples collected so far plus the one on the line right now.
    always_comb begin
        bit_tick  = (cnt == CNT_W'(BAUD_DIV - 1));
        finish    = 1'b0;
        stop1_val = rx_s;
        if (state == STOP2) begin
            finish    = bit_tick;
            stop1_val = stop1_q;
        end else if (state == STOP1 && STOP_BITS == 1) begin
            finish = bit_tick;
        end
        fe_val = !rx_s || !stop1_val;
        bd_val = (shreg == '0) && (PARITY == 0 || !par_bit_q) && !stop1_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop1_q    <= 1'b1;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            overrun <= 1'b0;
            if (valid && ready) valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    // Mid-bit check rejects glitches shorter than half a bit
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            state <= (PARITY != 0) ? PAR : STOP1;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (bit_tick) begin
                        cnt       <= '0;
                        par_bit_q <= rx_s;
                        par_err_q <= (PARITY == 1) ? !(^shreg ^ rx_s) : (^shreg ^ rx_s);
                        state     <= STOP1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP1: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        stop1_q <= rx_s;
                        if (STOP_BITS == 2) begin
                            state <= STOP2;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP2: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A held word is never overwritten; the new frame is dropped instead
            if (finish) begin
                if (!valid || ready) begin
                    data       <= shreg;
                    frame_err  <= fe_val;
                    parity_err <= (PARITY != 0) && par_err_q;
                    break_det  <= bd_val;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 7E2, 9O1) driven with
// directed frame vectors, corner sequences and random frames against a frame model.
module tb_uart_rx_param;

    logic       clk;
    logic       rst;
    logic [2:0] rxl;
    logic [2:0] rdy;
    logic [2:0] v, fe, pe, bd, ov, bz;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [8:0] d2;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int ovr_cnt[3];

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic [2:0] flags;
        int         cyc;
    } cap_t;

    typedef struct {
        int         dut;
        logic [8:0] din;
        bit         bpar;
        bit         bs1;
        bit         bs2;
        logic [8:0] edata;
        logic [2:0] eflags;
    } vec_t;

    cap_t capq[$];
    cap_t expq[$];
    vec_t tbl[13];

    uart_rx_param #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx(rxl[0]), .data(d0), .valid(v[0]), .ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .break_det(bd[0]), .overrun(ov[0]), .busy(bz[0]));

    uart_rx_param #(.BAUD_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .rst(rst), .rx(rxl[1]), .data(d1), .valid(v[1]), .ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .break_det(bd[1]), .overrun(ov[1]), .busy(bz[1]));

    uart_rx_param #(.BAUD_DIV(6), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_9o1 (
        .clk(clk), .rst(rst), .rx(rxl[2]), .data(d2), .valid(v[2]), .ready(rdy[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .break_det(bd[2]), .overrun(ov[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_b(input int i);
        return (i == 2) ? 6 : 16;
    endfunction
    function automatic int cfg_n(input int i);
        return (i == 0) ? 8 : (i == 1) ? 7 : 9;
    endfunction
    function automatic int cfg_p(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 1;
    endfunction
    function automatic int cfg_s(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic logic [8:0] dout(input int i);
        if (i == 0) return {1'b0, d0};
        if (i == 1) return {2'b00, d1};
        return d2;
    endfunction

    function automatic logic [8:0] mask_of(input int i);
        return 9'((1 << cfg_n(i)) - 1);
    endfunction

    // Correct parity bit for this configuration
    function automatic bit par_of(input int i, input logic [8:0] dv);
        int ones;
        ones = $countones(dv & mask_of(i));
        return (cfg_p(i) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    // Reference: {frame_err, parity_err, break_det} for the frame as sent
    function automatic logic [2:0] exp_flags(input int i, input logic [8:0] dv,
                                             input bit bpar, input bit bs1, input bit bs2);
        bit pbit, f, p, b;
        pbit = par_of(i, dv) ^ bpar;
        f = bs1 || (cfg_s(i) == 2 && bs2);
        p = (cfg_p(i) != 0) && bpar;
        b = ((dv & mask_of(i)) == 9'd0) && (cfg_p(i) == 0 || !pbit) && bs1;
        return {f, p, b};
    endfunction

    // valid is first visible one cycle after the last stop sample
    function automatic int exp_cyc(input int i, input int d);
        int k;
        k = cfg_n(i) + ((cfg_p(i) != 0) ? 1 : 0) + cfg_s(i);
        return d + 3 + cfg_b(i) / 2 + k * cfg_b(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Drives one frame; must be called at a negedge and returns at a negedge
    task automatic send(input int i, input logic [8:0] dv, input bit bpar,
                        input bit bs1, input bit bs2, output int d);
        logic fb[14];
        int   nb;
        fb[0] = 1'b0;
        nb = 1;
        for (int k = 0; k < cfg_n(i); k++) begin
            fb[nb] = dv[k];
            nb++;
        end
        if (cfg_p(i) != 0) begin
            fb[nb] = par_of(i, dv) ^ bpar;
            nb++;
        end
        fb[nb] = !bs1;
        nb++;
        if (cfg_s(i) == 2) begin
            fb[nb] = !bs2;
            nb++;
        end
        d = cyc;
        for (int k = 0; k < nb; k++) begin
            rxl[i] = fb[k];
            repeat (cfg_b(i)) @(negedge clk);
        end
        rxl[i] = 1'b1;
    endtask

    task automatic wait_cap(input int budget, output cap_t c, output bit ok);
        ok = 1'b0;
        c = '{default: 0};
        for (int k = 0; k < budget; k++) begin
            if (capq.size() > 0) begin
                c = capq.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        capq.delete();
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (v[i] && rdy[i]) capq.push_back('{i, dout(i), {fe[i], pe[i], bd[i]}, cyc});
            if (ov[i]) ovr_cnt[i]++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int   d;
        bit   ok;
        cap_t c;

        tbl[0]  = '{0, 9'h0A5, 0, 0, 0, 9'h0A5, 3'b000};
        tbl[1]  = '{1, 9'h041, 0, 0, 0, 9'h041, 3'b000};
        tbl[2]  = '{1, 9'h041, 1, 0, 0, 9'h041, 3'b010};
        tbl[3]  = '{0, 9'h03C, 0, 1, 0, 9'h03C, 3'b100};
        tbl[4]  = '{0, 9'h000, 0, 1, 0, 9'h000, 3'b101};
        tbl[5]  = '{1, 9'h000, 0, 1, 0, 9'h000, 3'b101};
        tbl[6]  = '{1, 9'h000, 1, 1, 0, 9'h000, 3'b110};
        tbl[7]  = '{1, 9'h07F, 0, 0, 1, 9'h07F, 3'b100};
        tbl[8]  = '{1, 9'h000, 0, 0, 1, 9'h000, 3'b100};
        tbl[9]  = '{2, 9'h1FF, 0, 0, 0, 9'h1FF, 3'b000};
        tbl[10] = '{2, 9'h000, 1, 0, 0, 9'h000, 3'b010};
        tbl[11] = '{2, 9'h000, 0, 1, 0, 9'h000, 3'b100};
        tbl[12] = '{0, 9'h0FF, 0, 0, 0, 9'h0FF, 3'b000};

        rst = 1'b1;
        rxl = 3'b111;
        rdy = 3'b111;
        for (int i = 0; i < 3; i++) ovr_cnt[i] = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out%0d", i),
                {dout(i), v[i], fe[i], pe[i], bd[i], ov[i], bz[i]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed frame vectors
        for (int t = 0; t < 13; t++) begin
            send(tbl[t].dut, tbl[t].din, tbl[t].bpar, tbl[t].bs1, tbl[t].bs2, d);
            repeat (2 * cfg_b(tbl[t].dut)) @(negedge clk);
            wait_cap(100, c, ok);
            chk($sformatf("vec%0d_seen", t), ok, 1);
            if (ok) begin
                chk($sformatf("vec%0d_data", t), c.data, tbl[t].edata);
                chk($sformatf("vec%0d_flags", t), c.flags, tbl[t].eflags);
                chk($sformatf("vec%0d_latency", t), c.cyc, exp_cyc(tbl[t].dut, d));
            end
            chk($sformatf("vec%0d_extra", t), capq.size(), 0);
        end

        // Short glitch on 8N1 is rejected at the start-bit check
        d = cyc;
        rxl[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxl[0] = 1'b1;
        chk("glitch_busy_hi", bz[0], 1);
        repeat (7) @(negedge clk);
        chk("glitch_busy_lo", bz[0], 0);
        repeat (40) @(negedge clk);
        chk("glitch_no_word", {capq.size() != 0, v[0]}, 0);

        // Line held low for two frame times reports a break
        d = cyc;
        rxl[0] = 1'b0;
        repeat (20 * 16) @(negedge clk);
        rxl[0] = 1'b1;
        wait_cap(10, c, ok);
        chk("break_seen", ok, 1);
        chk("break_word", {c.data, c.flags}, {9'h000, 3'b101});
        chk("break_latency", c.cyc, exp_cyc(0, d));
        repeat (30 * 16) @(negedge clk);
        do_reset();

        // Overrun: second back-to-back frame dropped while the first is held
        rdy[0] = 1'b0;
        ovr_cnt[0] = 0;
        send(0, 9'h011, 0, 0, 0, d);
        send(0, 9'h022, 0, 0, 0, d);
        repeat (16) @(negedge clk);
        chk("ovr_valid_held", v[0], 1);
        chk("ovr_data_held", dout(0), 9'h011);
        chk("ovr_flags_held", {fe[0], pe[0], bd[0]}, 3'b000);
        chk("ovr_pulse_cycles", ovr_cnt[0], 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_valid_cleared", v[0], 0);
        capq.delete();

        // Reset during bit 3 of 0xFF drops the frame and clears outputs at once
        send(0, 9'h0C3, 0, 0, 0, d);
        repeat (32) @(negedge clk);
        wait_cap(10, c, ok);
        chk("pre_rst_data", c.data, 9'h0C3);
        fork
            send(0, 9'h0FF, 0, 0, 0, d);
            begin
                repeat (4 * 16 + 8) @(negedge clk);
                rst = 1'b1;
                #1;
                chk("midrst_out", {dout(0), v[0], fe[0], pe[0], bd[0], ov[0], bz[0]}, 32'd0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        chk("midrst_no_word", capq.size(), 0);
        send(0, 9'h05A, 0, 0, 0, d);
        repeat (32) @(negedge clk);
        wait_cap(10, c, ok);
        chk("post_rst_seen", ok, 1);
        chk("post_rst_word", {c.data, c.flags}, {9'h05A, 3'b000});
        chk("post_rst_latency", c.cyc, exp_cyc(0, d));

        // Random frames on every configuration against the frame model
        for (int i = 0; i < 3; i++) ovr_cnt[i] = 0;
        for (int i = 0; i < 3; i++) begin
            capq.delete();
            expq.delete();
            for (int f = 0; f < 20; f++) begin
                logic [8:0] dv;
                bit         bpar, bs1, bs2, last_bad;
                int         gap;
                dv   = ($urandom % 6 == 0) ? 9'd0 : (9'($urandom) & mask_of(i));
                bpar = (cfg_p(i) != 0) && ($urandom % 6 == 0);
                bs1  = ($urandom % 7 == 0);
                bs2  = (cfg_s(i) == 2) && ($urandom % 7 == 0);
                send(i, dv, bpar, bs1, bs2, d);
                expq.push_back('{i, dv, exp_flags(i, dv, bpar, bs1, bs2), exp_cyc(i, d)});
                last_bad = (cfg_s(i) == 2) ? bs2 : bs1;
                if (last_bad) gap = cfg_b(i) + int'($urandom % cfg_b(i));
                else gap = ($urandom % 2 == 0) ? 0 : int'($urandom % (2 * cfg_b(i)));
                repeat (gap) @(negedge clk);
            end
            repeat (3 * cfg_b(i)) @(negedge clk);
            chk($sformatf("rand%0d_count", i), capq.size(), expq.size());
            while (capq.size() > 0 && expq.size() > 0) begin
                cap_t a, e;
                a = capq.pop_front();
                e = expq.pop_front();
                chk($sformatf("rand%0d_data", i), a.data, e.data);
                chk($sformatf("rand%0d_flags", i), a.flags, e.flags);
                chk($sformatf("rand%0d_latency", i), a.cyc, e.cyc);
            end
        end
        chk("rand_no_overrun", ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised asynchronous serial receiver. It supersedes the fixed 8N1 receiver and generalises data width, parity and stop-bit count. It adds start-bit validation, error flags and a valid/ready output handshake with overrun detection. It sits between the board RX pin and any byte consumer: command decoder, FIFO, or HyperRAM test controller.

Parameters:
BAUD_DIV, 104, clock cycles per bit (104 = 12 MHz / 115200); must be >= 4
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, asynchronous, active-high
rx  in  1  serial line; idle high; asynchronous to clk
data  out  DATA_BITS  received word
valid  out  1  data/flags held stable while high
ready  in  1  consumer accepts the word when valid && ready
frame_err  out  1  a sampled stop bit was 0; qualified by valid
parity_err  out  1  parity mismatch; qualified by valid; always 0 when PARITY=0
break_det  out  1  data all 0, parity bit 0 (if present) and first stop bit 0; qualified by valid
overrun  out  1  one-cycle pulse: a frame completed while valid && !ready
busy  out  1  high while not in IDLE

Behaviour:
- Reset values: data=0, valid=0, all flags=0, busy=0, state=IDLE. The synchroniser flops reset to 1 (idle line).
- rx passes through a 2-flop synchroniser; rx_s is the second flop. All logic uses rx_s.
- HALF = BAUD_DIV/2 (floor). A single baud counter is used, sized clog2(BAUD_DIV). It reloads at every state entry.
- States: IDLE, START, DATA, PAR, STOP1, STOP2.
- IDLE: the first cycle with rx_s=0 (cycle T0) enters START.
- START: sample rx_s at T0+HALF. If the sample is 1, treat it as a glitch and return to IDLE; nothing is reported. If 0, go to DATA.
- Bit k (k=0..) after the start sample is sampled at T0+HALF+(k+1)*BAUD_DIV.
- DATA: shift DATA_BITS samples LSB first. When the count is done, go to PAR if PARITY != 0, else STOP1.
- PAR: sample the parity bit. Odd parity passes when XOR(data, p) = 1. Even parity passes when XOR(data, p) = 0.
- STOP1: sample the stop bit. Go to STOP2 if STOP_BITS = 2, else complete the frame.
- STOP2: sample the second stop bit, then complete the frame. frame_err = either stop sample was 0.
- Completion occurs on the last stop-sample cycle, and the FSM returns to IDLE on that same cycle. A new start edge is therefore accepted from the middle of the stop bit, so back-to-back frames are supported.
- Output register, if valid=0 or (valid && ready) in the completion cycle: on the next cycle load data and the flags, and set valid=1. Latency from the last stop sample to valid is 1 cycle.
- Output register, if valid && !ready in the completion cycle: the new frame is dropped. Old data and flags stay unchanged, and overrun pulses high on the next cycle.
- valid clears on the cycle after valid && ready, unless a completion loads a new word in that same cycle, in which case valid stays 1.
- Frames with frame_err are still delivered. The receiver does not hunt for resync; the next falling edge in IDLE starts a new frame.
- Reset asserted mid-frame: return immediately to IDLE and clear all outputs. No partial word is ever delivered.
- busy = (state != IDLE).

Test Plan:
- Nominal 8N1, BAUD_DIV=16: send 0xA5 with ready=1 -> valid for 1 cycle, data=0xA5, no flags; valid rises 1 cycle after the stop sample.
- Glitch: rx low for 5 cycles, BAUD_DIV=16 -> START rejects it, busy returns to 0, valid never asserts.
- 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2): send 0x41 with correct parity 0 -> parity_err=0. Send 0x41 with parity bit 1 -> parity_err=1, data=0x41.
- Framing: 8N1 0x3C with stop bit 0 -> frame_err=1, data=0x3C. Line held low for 2 frame times -> break_det=1, frame_err=1, data=0x00.
- Handshake/overrun: ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11, valid stays 1, overrun pulses 1 cycle. Then ready=1 for 1 cycle -> valid=0.
- Reset mid-frame: assert rst during bit 3 of 0xFF -> outputs go to 0 immediately. Release rst, send 0x5A -> data=0x5A, correct.
